// File: rtl/rider_steer_seq_if.sv
// Rider-sequencer bus: load-cell samples and authorization in, rider/steer controls out.
interface rider_steer_seq_if;
    logic        vld;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        pwr_up;
    logic        rider_off;
    logic        en_steer;

    // Source of load-cell samples and authorization (A2D side / bench).
    modport master (
        output vld, lft_ld, rght_ld, pwr_up,
        input  rider_off, en_steer
    );

    // The sequencer itself.
    modport slave (
        input  vld, lft_ld, rght_ld, pwr_up,
        output rider_off, en_steer
    );
endinterface

// File: rtl/rider_steer_seq.sv
// Rider presence / steer-enable sequencer. Captures left/right load cells,
// applies hysteresis on their sum and a balance check on their difference,
// and only enables steering after the rider has stood still for a settle time.
module rider_steer_seq #(
    parameter bit          fast_sim     = 1'b1,
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h40
) (
    input  logic               clk,
    input  logic               rst,
    rider_steer_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        STEER_EN = 2'd2
    } state_t;

    // Thresholds are formed at 13 bits so they line up with the load-cell sum.
    localparam logic [12:0] SUM_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
    localparam logic [12:0] SUM_LO = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

    state_t      state_q, state_d;
    logic [25:0] tmr_q, tmr_d;
    logic [11:0] lft_q, lft_d;
    logic [11:0] rght_q, rght_d;
    logic        rider_off_q, rider_off_d;
    logic        en_steer_q, en_steer_d;

    logic [12:0] sum;
    logic [12:0] diff_raw;
    logic [12:0] diff_neg;
    logic [11:0] diff;
    logic        sum_gt_min;
    logic        sum_lt_min;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;
    logic        tmr_full;

    // Load-cell capture: hold the last valid sample between strobes.
    always_comb begin
        lft_d  = bus.vld ? bus.lft_ld  : lft_q;
        rght_d = bus.vld ? bus.rght_ld : rght_q;
    end

    // Weight sum, imbalance magnitude and the threshold comparisons built on them.
    always_comb begin
        sum           = {1'b0, lft_q} + {1'b0, rght_q};
        diff_raw      = {1'b0, lft_q} - {1'b0, rght_q};
        diff_neg      = 13'd0 - diff_raw;
        diff          = diff_raw[12] ? diff_neg[11:0] : diff_raw[11:0];
        sum_gt_min    = (sum > SUM_HI);
        sum_lt_min    = (sum < SUM_LO);
        diff_gt_1_4   = ({1'b0, diff} > (sum >> 2));
        diff_gt_15_16 = ({1'b0, diff} > (sum - (sum >> 4)));
        tmr_full      = fast_sim ? (&tmr_q[14:0]) : (&tmr_q);
    end

    // Next-state and next-output logic; the timer only survives a cycle when
    // WAIT holds with no disturbance, so every other path leaves it cleared.
    always_comb begin
        state_d = state_q;
        tmr_d   = 26'd0;
        if (!bus.pwr_up) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sum_gt_min) state_d = WAIT;
                end
                WAIT: begin
                    if (sum_lt_min)       state_d = IDLE;
                    else if (diff_gt_1_4) state_d = WAIT;
                    else if (tmr_full)    state_d = STEER_EN;
                    else                  tmr_d   = tmr_q + 26'd1;
                end
                STEER_EN: begin
                    if (sum_lt_min)         state_d = IDLE;
                    else if (diff_gt_15_16) state_d = WAIT;
                end
                default: state_d = IDLE;
            endcase
        end
        rider_off_d = (state_d == IDLE);
        en_steer_d  = (state_d == STEER_EN);
    end

    // State, timer, capture and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tmr_q       <= 26'd0;
            lft_q       <= 12'd0;
            rght_q      <= 12'd0;
            rider_off_q <= 1'b1;
            en_steer_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            lft_q       <= lft_d;
            rght_q      <= rght_d;
            rider_off_q <= rider_off_d;
            en_steer_q  <= en_steer_d;
        end
    end

    assign bus.rider_off = rider_off_q;
    assign bus.en_steer  = en_steer_q;

endmodule

// File: tb/tb_rider_steer_seq.sv
// Bench for rider_steer_seq: scenario tasks push expected rider_off/en_steer
// pairs and settle latencies into queues, then pop and compare once the DUT responds.
module tb_rider_steer_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rider_steer_seq_if bus ();

    rider_steer_seq #(
        .fast_sim     (1'b1),
        .MIN_RIDER_WT (12'h200),
        .WT_HYST      (12'h40)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string name;
        logic  ro;
        logic  es;
    } exp_t;

    exp_t sb[$];
    int   lat_q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam int SETTLE = 32768;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle vld strobe; returns at the negedge after the capture edge.
    task automatic send(input logic [11:0] l, input logic [11:0] r);
        bus.lft_ld  = l;
        bus.rght_ld = r;
        bus.vld     = 1'b1;
        tick(1);
        bus.vld     = 1'b0;
    endtask

    task automatic push(input string nm, input logic ro, input logic es);
        exp_t e;
        e.name = nm;
        e.ro   = ro;
        e.es   = es;
        sb.push_back(e);
    endtask

    // Counts clocks until en_steer rises (bounded); optionally re-strobes a sample at one count.
    task automatic wait_steer(input int resample_at, input logic [11:0] l,
                              input logic [11:0] r, output int cnt);
        cnt = 0;
        for (int i = 0; i < 40000; i++) begin
            if (i == resample_at) begin
                bus.lft_ld  = l;
                bus.rght_ld = r;
                bus.vld     = 1'b1;
            end else begin
                bus.vld = 1'b0;
            end
            tick(1);
            cnt++;
            if (bus.en_steer === 1'b1) begin
                bus.vld = 1'b0;
                return;
            end
        end
        bus.vld = 1'b0;
        cnt = -1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst         = 1'b1;
        bus.pwr_up  = 1'b1;
        bus.vld     = 1'b1;
        bus.lft_ld  = 12'h300;
        bus.rght_ld = 12'h300;
        tick(2);
        push("reset_state", 1'b1, 1'b0);
        e = sb.pop_front(); checks++;
        if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
            failures++;
            $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
        end
        bus.vld = 1'b0;
        rst     = 1'b0;
        tick(3);
        push("post_reset_idle", 1'b1, 1'b0);
        e = sb.pop_front(); checks++;
        if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
            failures++;
            $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
        end
    endtask

    task automatic test_mount_lean();
        exp_t e;
        int   cnt;
        int   exp_lat;
        send(12'h180, 12'h180);
        tick(1);
        push("mount_rider_on", 1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
            failures++;
            $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
        end
        tick(16384);
        push("settle_not_early", 1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
            failures++;
            $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
        end
        // Lean for one sample, then rebalance; the lean is judged on the rebalance edge.
        send(12'h200, 12'h0E0);
        send(12'h180, 12'h180);
        push("lean_holds_wait", 1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
            failures++;
            $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
        end
        lat_q.push_back(SETTLE);
        wait_steer(-1, 12'h180, 12'h180, cnt);
        exp_lat = lat_q.pop_front(); checks++;
        if (cnt != exp_lat) begin
            failures++;
            $display("FAIL lean_settle_latency clocks got %0d want %0d", cnt, exp_lat);
        end
        push("lean_settled_steer", 1'b0, 1'b1);
        e = sb.pop_front(); checks++;
        if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
            failures++;
            $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
        end
    endtask

    task automatic test_steer_hysteresis();
        exp_t        e;
        logic [11:0] ld [3]  = '{12'h0E8, 12'h0E0, 12'h0D8};
        logic        ro [3]  = '{1'b0, 1'b0, 1'b1};
        logic        es [3]  = '{1'b1, 1'b1, 1'b0};
        string       nm [3]  = '{"steer_sum_1d0", "steer_sum_1c0", "stepoff_sum_1b0"};
        for (int i = 0; i < 3; i++) begin
            send(ld[i], ld[i]);
            push(nm[i], ro[i], es[i]);
            tick(1);
            e = sb.pop_front(); checks++;
            if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
                failures++;
                $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
            end
        end
    endtask

    task automatic test_idle_hysteresis();
        exp_t e;
        send(12'h120, 12'h120);
        push("idle_sum_240", 1'b1, 1'b0);
        tick(1);
        e = sb.pop_front(); checks++;
        if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
            failures++;
            $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
        end
        send(12'h121, 12'h120);
        push("idle_sum_241", 1'b0, 1'b0);
        tick(1);
        e = sb.pop_front(); checks++;
        if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
            failures++;
            $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
        end
    endtask

    // Balanced resample mid-settle (diff=0) must not restart the timer.
    task automatic test_diff_zero_settle();
        exp_t e;
        int   cnt;
        int   exp_lat;
        lat_q.push_back(SETTLE);
        wait_steer(10000, 12'h180, 12'h180, cnt);
        exp_lat = lat_q.pop_front(); checks++;
        if (cnt != exp_lat) begin
            failures++;
            $display("FAIL diff0_settle_latency clocks got %0d want %0d", cnt, exp_lat);
        end
        push("settled_again", 1'b0, 1'b1);
        e = sb.pop_front(); checks++;
        if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
            failures++;
            $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
        end
    endtask

    task automatic test_one_foot_overflow();
        exp_t        e;
        logic [11:0] l  [3] = '{12'hFFF, 12'h3F0, 12'hFFF};
        logic [11:0] r  [3] = '{12'hFFF, 12'h010, 12'h001};
        logic        es [3] = '{1'b1, 1'b0, 1'b0};
        string       nm [3] = '{"max_load_steer", "one_foot_wait", "sum_1000_no_wrap"};
        for (int i = 0; i < 3; i++) begin
            send(l[i], r[i]);
            push(nm[i], 1'b0, es[i]);
            tick(1);
            e = sb.pop_front(); checks++;
            if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
                failures++;
                $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
            end
        end
    endtask

    task automatic test_pwr_up();
        exp_t e;
        bus.pwr_up  = 1'b0;
        bus.lft_ld  = 12'h180;
        bus.rght_ld = 12'h180;
        bus.vld     = 1'b1;
        push("pwr_down_idle", 1'b1, 1'b0);
        tick(1);
        bus.vld    = 1'b0;
        bus.pwr_up = 1'b1;
        e = sb.pop_front(); checks++;
        if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
            failures++;
            $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
        end
        push("pwr_restore_wait", 1'b0, 1'b0);
        tick(1);
        e = sb.pop_front(); checks++;
        if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
            failures++;
            $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
        end
        push("restart_no_early", 1'b0, 1'b0);
        tick(1000);
        e = sb.pop_front(); checks++;
        if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
            failures++;
            $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
        end
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        rst = 1'b1;
        push("rst_mid_wait", 1'b1, 1'b0);
        tick(1);
        rst = 1'b0;
        e = sb.pop_front(); checks++;
        if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
            failures++;
            $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
        end
        push("rst_loads_cleared", 1'b1, 1'b0);
        tick(2);
        e = sb.pop_front(); checks++;
        if (bus.rider_off !== e.ro || bus.en_steer !== e.es) begin
            failures++;
            $display("FAIL %s rider_off/en_steer got %b/%b want %b/%b", e.name, bus.rider_off, bus.en_steer, e.ro, e.es);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.vld     = 1'b0;
        bus.lft_ld  = 12'h000;
        bus.rght_ld = 12'h000;
        bus.pwr_up  = 1'b1;
        test_reset();
        test_mount_lean();
        test_steer_hysteresis();
        test_idle_hysteresis();
        test_diff_zero_settle();
        test_one_foot_overflow();
        test_pwr_up();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
